// File: rtl/trace_port_tx.sv
// trace_port_tx: TPIU-style DDR trace transmitter, 1/2/4 lanes, 16-byte frames.
// Optional feature macro TRACE_TX_STATS_EN adds the frameCount output.
module trace_port_tx #(
   parameter int SYNC_INTERVAL = 16,
   parameter int MAX_BUS_WIDTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  width,
   input  logic [15:0] PacketWd,
   input  logic        WdAvail,
   output logic        WdTaken,
   output logic [3:0]  traceDout,
   output logic        traceClkOut,
   output logic        sync,
`ifdef TRACE_TX_STATS_EN
   output logic [15:0] frameCount,
`endif
   output logic        txActive
);

   typedef enum logic {
      S_FSYNC,
      S_FRAME
   } state_t;

   localparam logic [15:0] ONES    = 16'hFFFF;
   localparam logic [15:0] HW_SYNC = 16'h7FFF;
   localparam logic [3:0]  FULL    = 4'((1 << MAX_BUS_WIDTH) - 1);
   localparam logic [7:0]  SI8     = 8'(SYNC_INTERVAL);

   function automatic logic [2:0] dec_w(input logic [2:0] w);
      case (w)
         3'd1:    dec_w = 3'd1;
         3'd2:    dec_w = 3'd2;
         default: dec_w = 3'd4;
      endcase
   endfunction

   function automatic logic [3:0] lane_mask(input logic [2:0] w);
      case (w)
         3'd1:    lane_mask = 4'h1;
         3'd2:    lane_mask = 4'h3;
         default: lane_mask = FULL;
      endcase
   endfunction

   function automatic logic [3:0] beats_m1(input logic [2:0] w);
      case (w)
         3'd1:    beats_m1 = 4'd15;
         3'd2:    beats_m1 = 4'd7;
         default: beats_m1 = 4'd3;
      endcase
   endfunction

   state_t      state_q, state_d;
   logic [1:0]  hw_q, hw_d;
   logic [2:0]  slot_q, slot_d;
   logic [3:0]  left_q, left_d;
   logic [15:0] shift_q, shift_d;
   logic [2:0]  wid_q, wid_d;
   logic [7:0]  fcnt_q, fcnt_d;
   logic [3:0]  dout_q, dout_d;
   logic        tclk_q, tclk_d;
   logic        sync_q, sync_d;
   logic        act_q, act_d;
`ifdef TRACE_TX_STATS_EN
   logic [15:0] stats_q, stats_d;
`endif

   logic        last;
   logic        frame_last;
   logic        to_sync;
   logic        take;
   logic [7:0]  fcnt_inc;
   logic        ld;
   logic        latch;
   logic        ld_sync;
   logic        ld_act;
   logic [15:0] ld_val;
   logic [2:0]  w_use;

   // State register: all flops, synchronous active-high reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FSYNC;
         hw_q    <= 2'd0;
         slot_q  <= 3'd0;
         left_q  <= 4'd0;
         shift_q <= 16'h0;
         wid_q   <= 3'd4;
         fcnt_q  <= 8'd0;
         dout_q  <= 4'h0;
         tclk_q  <= 1'b0;
         sync_q  <= 1'b0;
         act_q   <= 1'b0;
`ifdef TRACE_TX_STATS_EN
         stats_q <= 16'h0;
`endif
      end else begin
         state_q <= state_d;
         hw_q    <= hw_d;
         slot_q  <= slot_d;
         left_q  <= left_d;
         shift_q <= shift_d;
         wid_q   <= wid_d;
         fcnt_q  <= fcnt_d;
         dout_q  <= dout_d;
         tclk_q  <= tclk_d;
         sync_q  <= sync_d;
         act_q   <= act_d;
`ifdef TRACE_TX_STATS_EN
         stats_q <= stats_d;
`endif
      end
   end

   // Next state: pick the next halfword at each halfword end, else shift out
   always_comb begin
      state_d = state_q;
      hw_d    = hw_q;
      slot_d  = slot_q;
      fcnt_d  = fcnt_q;
      ld      = 1'b0;
      latch   = 1'b0;
      ld_sync = 1'b0;
      ld_act  = 1'b0;
      ld_val  = shift_q;
      if (last) begin
         unique case (state_q)
            S_FSYNC: begin
               if (hw_q == 2'd2) begin
                  state_d = S_FRAME;
                  hw_d    = 2'd0;
                  slot_d  = 3'd0;
                  latch   = 1'b1;
               end else begin
                  ld      = 1'b1;
                  ld_sync = 1'b1;
                  latch   = (hw_q == 2'd0);
                  ld_val  = (hw_q == 2'd0) ? ONES : HW_SYNC;
                  hw_d    = hw_q + 2'd1;
               end
            end
            S_FRAME: begin
               if (frame_last) begin
                  fcnt_d = fcnt_inc;
                  slot_d = 3'd0;
                  latch  = 1'b1;
                  if (to_sync) begin
                     fcnt_d  = 8'd0;
                     state_d = S_FSYNC;
                     ld      = 1'b1;
                     ld_sync = 1'b1;
                     ld_val  = ONES;
                     hw_d    = 2'd1;
                  end
               end else begin
                  slot_d = slot_q + 3'd1;
               end
            end
         endcase
         if (take) begin
            ld     = 1'b1;
            ld_act = WdAvail;
            ld_val = WdAvail ? PacketWd : HW_SYNC;
         end
      end
      w_use  = latch ? dec_w(width) : wid_q;
      wid_d  = wid_q;
      sync_d = sync_q;
      act_d  = act_q;
      if (ld) begin
         wid_d   = w_use;
         dout_d  = ld_val[3:0] & lane_mask(w_use);
         shift_d = ld_val >> w_use;
         left_d  = beats_m1(w_use);
         sync_d  = ld_sync;
         act_d   = ld_act;
      end else begin
         dout_d  = shift_q[3:0] & lane_mask(wid_q);
         shift_d = shift_q >> wid_q;
         left_d  = left_q - 4'd1;
      end
      tclk_d = ~tclk_q;
`ifdef TRACE_TX_STATS_EN
      stats_d = stats_q;
      if (state_q == S_FRAME && slot_q == 3'd7 && left_q == 4'd1)
         stats_d = stats_q + 16'd1;
`endif
   end

   // Outputs: load strobe toward the source plus registered bus signals
   always_comb begin
      last       = (left_q == 4'd0);
      fcnt_inc   = fcnt_q + 8'd1;
      frame_last = (state_q == S_FRAME) && (slot_q == 3'd7);
      to_sync    = frame_last && (fcnt_inc == SI8);
      take       = last &&
                   (((state_q == S_FSYNC) && (hw_q == 2'd2)) ||
                    ((state_q == S_FRAME) && !to_sync));
      WdTaken     = take;
      traceDout   = dout_q;
      traceClkOut = tclk_q;
      sync        = sync_q;
      txActive    = act_q;
`ifdef TRACE_TX_STATS_EN
      frameCount  = stats_q;
`endif
   end

endmodule

// File: tb/tb_trace_port_tx.sv
// tb_trace_port_tx: scoreboard bench for trace_port_tx.
// Covers sync framing, data latency, widths, width change, mid-word reset.
module tb_trace_port_tx;

   localparam int SI = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  width;
   logic [15:0] PacketWd;
   logic        WdAvail;
   logic        WdTaken;
   logic [3:0]  traceDout;
   logic        traceClkOut;
   logic        sync;
   logic        txActive;
`ifdef TRACE_TX_STATS_EN
   logic [15:0] frameCount;
`endif

   typedef struct packed {
      logic [3:0] d;
      logic       s;
      logic       a;
   } beat_t;

   beat_t q[$];
   int    n_pass = 0;
   int    n_total = 0;

   always #5 clk = ~clk;

   trace_port_tx #(
      .SYNC_INTERVAL(SI),
      .MAX_BUS_WIDTH(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .width(width),
      .PacketWd(PacketWd),
      .WdAvail(WdAvail),
      .WdTaken(WdTaken),
      .traceDout(traceDout),
      .traceClkOut(traceClkOut),
      .sync(sync),
`ifdef TRACE_TX_STATS_EN
      .frameCount(frameCount),
`endif
      .txActive(txActive)
   );

   task automatic push_hw(input logic [15:0] v, input int w,
                          input logic s, input logic a);
      logic [15:0] sh;
      logic [3:0]  m;
      beat_t       b;
      sh = v;
      m = (w == 1) ? 4'h1 : (w == 2) ? 4'h3 : 4'hF;
      for (int i = 0; i < 16 / w; i++) begin
         b.d = sh[3:0] & m;
         b.s = s;
         b.a = a;
         q.push_back(b);
         sh = sh >> w;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      width = 3'd4;
      WdAvail = 1'b0;
      PacketWd = 16'h0;
      repeat (3) @(negedge clk);
      n_total++;
      if (traceDout !== 4'h0)
         $display("FAIL rst_dout: got %h expected 0", traceDout);
      else n_pass++;
      n_total++;
      if (traceClkOut !== 1'b0)
         $display("FAIL rst_clk: got %b expected 0", traceClkOut);
      else n_pass++;
      n_total++;
      if (WdTaken !== 1'b0)
         $display("FAIL rst_taken: got %b expected 0", WdTaken);
      else n_pass++;
      n_total++;
      if (sync !== 1'b0)
         $display("FAIL rst_sync: got %b expected 0", sync);
      else n_pass++;
      n_total++;
      if (txActive !== 1'b0)
         $display("FAIL rst_act: got %b expected 0", txActive);
      else n_pass++;
`ifdef TRACE_TX_STATS_EN
      n_total++;
      if (frameCount !== 16'h0)
         $display("FAIL rst_fc: got %h expected 0", frameCount);
      else n_pass++;
`endif
   endtask

   task automatic test_fsync();
      beat_t e;
      logic  prev_clk;
      q.delete();
      push_hw(16'hFFFF, 4, 1'b1, 1'b0);
      push_hw(16'h7FFF, 4, 1'b1, 1'b0);
      repeat (8) push_hw(16'h7FFF, 4, 1'b0, 1'b0);
      prev_clk = traceClkOut;
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         e = q.pop_front();
         n_total++;
         if ({traceDout, sync, txActive} !== {e.d, e.s, e.a})
            $display("FAIL fsync_beat%0d: got %h/%b/%b expected %h/%b/%b",
                     i, traceDout, sync, txActive, e.d, e.s, e.a);
         else n_pass++;
         n_total++;
         if (traceClkOut !== ~prev_clk)
            $display("FAIL fsync_clk%0d: got %b expected %b",
                     i, traceClkOut, ~prev_clk);
         else n_pass++;
         prev_clk = traceClkOut;
         n_total++;
         if (WdTaken !== (i >= 7 && (i % 4) == 3))
            $display("FAIL fsync_taken%0d: got %b expected %b",
                     i, WdTaken, (i >= 7 && (i % 4) == 3));
         else n_pass++;
`ifdef TRACE_TX_STATS_EN
         if (i >= 38) begin
            n_total++;
            if (frameCount !== ((i == 39) ? 16'd1 : 16'd0))
               $display("FAIL fsync_fc%0d: got %0d expected %0d",
                        i, frameCount, (i == 39) ? 1 : 0);
            else n_pass++;
         end
`endif
      end
   endtask

   task automatic wait_sync(output bit ok);
      bit prev;
      prev = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (sync && !prev) begin
            ok = 1'b1;
            break;
         end
         prev = sync;
      end
   endtask

   task automatic run_stream(input int w0, input int w1, input int nsw,
                             input int ncyc, input logic [15:0] word,
                             input bit rnd, input string tag);
      beat_t e;
      int    hs, last_take, last_beats, sync_run, tk_sync, tk_rise, wc, exp_gap;
      bit    in_sync, rise_seen, sync_since, stop, upd;
      hs = 0;
      last_take = -1;
      last_beats = 0;
      sync_run = 0;
      tk_sync = 0;
      tk_rise = 0;
      in_sync = sync;
      rise_seen = 1'b0;
      sync_since = 1'b0;
      stop = 1'b0;
      upd = 1'b0;
      q.delete();
      width = 3'(w0);
      PacketWd = word;
      WdAvail = 1'b1;
      for (int c = 0; c < ncyc + 100; c++) begin
         if (WdAvail && WdTaken) begin
            wc = (hs < nsw) ? w0 : w1;
            if (last_take >= 0) begin
               exp_gap = last_beats + (sync_since ? 32 / w1 : 0);
               n_total++;
               if (c - last_take !== exp_gap)
                  $display("FAIL %s_gap: got %0d expected %0d",
                           tag, c - last_take, exp_gap);
               else n_pass++;
            end
            push_hw(PacketWd, wc, 1'b0, 1'b1);
            last_take = c;
            last_beats = 16 / wc;
            sync_since = 1'b0;
            hs++;
            tk_rise++;
            upd = 1'b1;
            if (c >= ncyc) stop = 1'b1;
         end
         @(negedge clk);
         if (upd) begin
            upd = 1'b0;
            if (stop) WdAvail = 1'b0;
            PacketWd = rnd ? 16'($urandom) : word;
            if (hs == 3) width = 3'(w1);
         end
         if (q.size() > 0) begin
            e = q.pop_front();
            n_total++;
            if ({traceDout, sync, txActive} !== {e.d, e.s, e.a})
               $display("FAIL %s_beat: got %h/%b/%b expected %h/%b/%b",
                        tag, traceDout, sync, txActive, e.d, e.s, e.a);
            else n_pass++;
         end else begin
            n_total++;
            if (txActive !== 1'b0)
               $display("FAIL %s_idle: got act %b expected 0",
                        tag, txActive);
            else n_pass++;
         end
         if (sync && !in_sync) begin
            if (rise_seen && !stop) begin
               n_total++;
               if (tk_rise !== 16)
                  $display("FAIL %s_hw_per_sync: got %0d expected 16",
                           tag, tk_rise);
               else n_pass++;
            end
            rise_seen = 1'b1;
            sync_since = 1'b1;
            tk_rise = 0;
            sync_run = 0;
            tk_sync = 0;
         end
         if (sync) begin
            sync_run++;
            if (WdTaken) tk_sync++;
         end
         if (!sync && in_sync && rise_seen) begin
            n_total++;
            if (sync_run !== 32 / w1)
               $display("FAIL %s_sync_len: got %0d expected %0d",
                        tag, sync_run, 32 / w1);
            else n_pass++;
            n_total++;
            if (tk_sync !== 1)
               $display("FAIL %s_sync_taken: got %0d expected 1",
                        tag, tk_sync);
            else n_pass++;
         end
         in_sync = sync;
         if (stop && !WdAvail && q.size() == 0) break;
      end
      n_total++;
      if (q.size() != 0 || WdAvail)
         $display("FAIL %s_drain: got %0d beats left expected 0",
                  tag, q.size());
      else n_pass++;
      WdAvail = 1'b0;
   endtask

   task automatic test_data_w4();
      run_stream(4, 4, 0, 120, 16'h1234, 1'b0, "w4");
   endtask

   task automatic test_width1();
      bit ok;
      width = 3'd1;
      wait_sync(ok);
      n_total++;
      if (!ok) $display("FAIL w1_wait: got timeout expected sync");
      else n_pass++;
      run_stream(1, 1, 0, 150, 16'hA5C3, 1'b0, "w1");
   endtask

   task automatic test_width_change();
      bit ok;
      width = 3'd4;
      wait_sync(ok);
      n_total++;
      if (!ok) $display("FAIL wchg_wait: got timeout expected sync");
      else n_pass++;
      run_stream(4, 2, 8, 150, 16'h0, 1'b1, "wchg");
   endtask

   task automatic test_back_to_back_reset();
      beat_t e;
      bit    ok;
      width = 3'd2;
      PacketWd = 16'hBEEF;
      WdAvail = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (txActive) begin
            ok = 1'b1;
            break;
         end
      end
      n_total++;
      if (!ok) $display("FAIL rmid_wait: got timeout expected data");
      else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      n_total++;
      if ({traceDout, traceClkOut, WdTaken, sync, txActive} !== 8'h0)
         $display("FAIL rmid_zero: got %h expected 00",
                  {traceDout, traceClkOut, WdTaken, sync, txActive});
      else n_pass++;
`ifdef TRACE_TX_STATS_EN
      n_total++;
      if (frameCount !== 16'h0)
         $display("FAIL rmid_fc: got %h expected 0", frameCount);
      else n_pass++;
`endif
      rst = 1'b0;
      q.delete();
      push_hw(16'hFFFF, 2, 1'b1, 1'b0);
      push_hw(16'h7FFF, 2, 1'b1, 1'b0);
      push_hw(16'hBEEF, 2, 1'b0, 1'b1);
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         e = q.pop_front();
         n_total++;
         if ({traceDout, sync, txActive} !== {e.d, e.s, e.a})
            $display("FAIL rmid_beat%0d: got %h/%b/%b expected %h/%b/%b",
                     i, traceDout, sync, txActive, e.d, e.s, e.a);
         else n_pass++;
         n_total++;
         if (WdTaken !== (i == 15 || i == 23))
            $display("FAIL rmid_taken%0d: got %b expected %b",
                     i, WdTaken, (i == 15 || i == 23));
         else n_pass++;
      end
      WdAvail = 1'b0;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      width = 3'd4;
      WdAvail = 1'b0;
      PacketWd = 16'h0;
      test_reset();
      test_fsync();
      test_data_w4();
      test_width1();
      test_width_change();
      test_back_to_back_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
